// File: rtl/hd44780_rx_if.sv
// Bus bundle for the 4-bit HD44780 character-LCD interface.
// The display driver owns the master side; the receiver mirror is the slave.
interface hd44780_rx_if;
    logic       lcd_rs;
    logic       lcd_en;
    logic [3:0] lcd_d;

    modport master (output lcd_rs, lcd_en, lcd_d);
    modport slave  (input  lcd_rs, lcd_en, lcd_d);
endinterface

// File: rtl/hd44780_rx.sv
// hd44780_rx: receive-side mirror of an HD44780 character LCD on a 4-bit bus.
//
// Samples rs/en/d, rebuilds bytes on lcd_en falling edges and decodes the
// command subset used by our drivers. It keeps a 2x16 shadow of the visible
// DDRAM, which can be read back one cycle after rd_addr is presented.
//
// Optional build macro: HD44780_TIMING_CHECK_EN
//   When defined, lcd_en pulses shorter than MIN_EN_HIGH cycles are dropped
//   and flagged on the sticky timing_err output.
//
// Nibble FSM:
//   state   | meaning
//   PH_HIGH | waiting for the upper nibble (also the only state in 8-bit mode)
//   PH_LOW  | upper nibble held, waiting for the lower nibble
module hd44780_rx #(
    parameter int SYNC_STAGES  = 2,
    parameter int CLEAR_CYCLES = 32,
    parameter int MIN_EN_HIGH  = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    hd44780_rx_if.slave        lcd,
    output logic               byte_valid,
    output logic               byte_rs,
    output logic [7:0]         byte_data,
    output logic               four_bit,
    output logic               disp_on,
    output logic [6:0]         cur_addr,
    output logic               clear_busy,
    output logic               proto_err,
    output logic               timing_err,
    input  logic [4:0]         rd_addr,
    output logic [7:0]         rd_char
);

    typedef enum logic {PH_HIGH = 1'b0, PH_LOW = 1'b1} phase_e;

    localparam int CW = $clog2(CLEAR_CYCLES + 1);

    if (SYNC_STAGES < 2 || CLEAR_CYCLES < 32 || MIN_EN_HIGH < 1) begin : g_param_err
        $error("hd44780_rx: illegal parameter value");
    end

    // ---------------------------------------------------------------------
    // Input synchronisers and falling-edge detect
    // ---------------------------------------------------------------------
    logic [SYNC_STAGES-1:0]      sync_rs_q, sync_rs_d;
    logic [SYNC_STAGES-1:0]      sync_en_q, sync_en_d;
    logic [SYNC_STAGES-1:0][3:0] sync_dat_q, sync_dat_d;
    logic                        en_prev_q, en_prev_d;
    logic                        en_s, rs_s;
    logic [3:0]                  dat_s;
    logic                        fall;
    logic                        pulse_ok;

    // shift each bus line through its synchroniser chain
    always_comb begin
        sync_rs_d  = {sync_rs_q[SYNC_STAGES-2:0], lcd.lcd_rs};
        sync_en_d  = {sync_en_q[SYNC_STAGES-2:0], lcd.lcd_en};
        sync_dat_d = {sync_dat_q[SYNC_STAGES-2:0], lcd.lcd_d};
        en_s       = sync_en_q[SYNC_STAGES-1];
        rs_s       = sync_rs_q[SYNC_STAGES-1];
        dat_s      = sync_dat_q[SYNC_STAGES-1];
        en_prev_d  = en_s;
        fall       = en_prev_q & ~en_s;
    end

    // synchroniser and edge-detect registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_rs_q  <= '0;
            sync_en_q  <= '0;
            sync_dat_q <= '0;
            en_prev_q  <= 1'b0;
        end else begin
            sync_rs_q  <= sync_rs_d;
            sync_en_q  <= sync_en_d;
            sync_dat_q <= sync_dat_d;
            en_prev_q  <= en_prev_d;
        end
    end

`ifdef HD44780_TIMING_CHECK_EN
    localparam int TW = $clog2(MIN_EN_HIGH + 1);

    logic [TW-1:0] en_cnt_q, en_cnt_d;
    logic          timing_err_q, timing_err_d;

    // measure synchronised en high time, saturating at the minimum
    always_comb begin
        en_cnt_d = en_cnt_q;
        if (!en_s) begin
            en_cnt_d = '0;
        end else if (en_cnt_q != TW'(MIN_EN_HIGH)) begin
            en_cnt_d = en_cnt_q + 1'b1;
        end
        pulse_ok     = (en_cnt_q == TW'(MIN_EN_HIGH));
        timing_err_d = timing_err_q | (fall & ~pulse_ok);
    end

    // pulse-width counter and sticky timing error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_cnt_q     <= '0;
            timing_err_q <= 1'b0;
        end else begin
            en_cnt_q     <= en_cnt_d;
            timing_err_q <= timing_err_d;
        end
    end

    assign timing_err = timing_err_q;
`else
    assign pulse_ok   = 1'b1;
    assign timing_err = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // Edge event stage: latch rs/nibble in the cycle the edge is seen
    // ---------------------------------------------------------------------
    logic       ev_q, ev_d;
    logic       ev_rs_q, ev_rs_d;
    logic [3:0] ev_nib_q, ev_nib_d;

    // capture an accepted falling edge together with its rs and nibble
    always_comb begin
        ev_d     = fall & pulse_ok;
        ev_rs_d  = rs_s;
        ev_nib_d = dat_s;
    end

    // event registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_q     <= 1'b0;
            ev_rs_q  <= 1'b0;
            ev_nib_q <= 4'h0;
        end else begin
            ev_q     <= ev_d;
            ev_rs_q  <= ev_rs_d;
            ev_nib_q <= ev_nib_d;
        end
    end

    // ---------------------------------------------------------------------
    // Byte assembly, command decode and display RAM shadow
    // ---------------------------------------------------------------------
    phase_e        phase_q, phase_d;
    logic          hi_rs_q, hi_rs_d;
    logic [3:0]    hi_nib_q, hi_nib_d;
    logic          byte_valid_q, byte_valid_d;
    logic          byte_rs_q, byte_rs_d;
    logic [7:0]    byte_data_q, byte_data_d;
    logic          four_bit_q, four_bit_d;
    logic          disp_on_q, disp_on_d;
    logic [6:0]    cur_addr_q, cur_addr_d;
    logic          inc_q, inc_d;
    logic          cg_sel_q, cg_sel_d;
    logic          proto_err_q, proto_err_d;
    logic [CW-1:0] clr_cnt_q, clr_cnt_d;
    logic [7:0]    cells_q [32];
    logic [7:0]    cells_d [32];
    logic [7:0]    rd_char_q, rd_char_d;
    logic          got_byte;
    logic [7:0]    nb;
    logic          busy;

    // DDRAM address counter step with the two-line wrap points
    function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
        logic [6:0] r;
        if (inc) begin
            if (a == 7'h27)      r = 7'h40;
            else if (a == 7'h67) r = 7'h00;
            else                 r = a + 7'd1;
        end else begin
            if (a == 7'h40)      r = 7'h27;
            else if (a == 7'h00) r = 7'h67;
            else                 r = a - 7'd1;
        end
        return r;
    endfunction

    // nibble FSM, byte decode, clear fill and readback
    always_comb begin
        phase_d      = phase_q;
        hi_rs_d      = hi_rs_q;
        hi_nib_d     = hi_nib_q;
        byte_valid_d = 1'b0;
        byte_rs_d    = byte_rs_q;
        byte_data_d  = byte_data_q;
        four_bit_d   = four_bit_q;
        disp_on_d    = disp_on_q;
        cur_addr_d   = cur_addr_q;
        inc_d        = inc_q;
        cg_sel_d     = cg_sel_q;
        proto_err_d  = proto_err_q;
        clr_cnt_d    = clr_cnt_q;
        cells_d      = cells_q;
        got_byte     = 1'b0;
        nb           = 8'h00;
        busy         = (clr_cnt_q != '0);

        // clear fills one cell per cycle during the last 32 busy cycles
        if (busy) begin
            clr_cnt_d = clr_cnt_q - 1'b1;
            if (clr_cnt_q <= CW'(32)) begin
                cells_d[5'(clr_cnt_q - 1'b1)] = 8'h20;
            end
        end

        if (ev_q) begin
            if (!four_bit_q) begin
                got_byte = 1'b1;
                nb       = {ev_nib_q, 4'h0};
            end else begin
                case (phase_q)
                    PH_HIGH: begin
                        hi_nib_d = ev_nib_q;
                        hi_rs_d  = ev_rs_q;
                        phase_d  = PH_LOW;
                    end
                    default: begin
                        phase_d = PH_HIGH;
                        if (ev_rs_q != hi_rs_q) begin
                            proto_err_d = 1'b1;
                        end else begin
                            got_byte = 1'b1;
                            nb       = {hi_nib_q, ev_nib_q};
                        end
                    end
                endcase
            end
        end

        if (got_byte) begin
            byte_valid_d = 1'b1;
            byte_rs_d    = ev_rs_q;
            byte_data_d  = nb;
            if (busy) begin
                proto_err_d = 1'b1;
            end else if (ev_rs_q) begin
                if (!cg_sel_q) begin
                    // only 0x00-0x0F and 0x40-0x4F are visible cells
                    if (cur_addr_q[5:4] == 2'b00) begin
                        cells_d[{cur_addr_q[6], cur_addr_q[3:0]}] = nb;
                    end
                    cur_addr_d = step_addr(cur_addr_q, inc_q);
                end
            end else begin
                if (nb[7]) begin
                    cur_addr_d = nb[6:0];
                    cg_sel_d   = 1'b0;
                end else if (nb[6]) begin
                    cg_sel_d = 1'b1;
                end else if (nb[5]) begin
                    four_bit_d = ~nb[4];
                    phase_d    = PH_HIGH;
                end else if (nb[3]) begin
                    disp_on_d = nb[2];
                end else if (nb[2]) begin
                    inc_d = nb[1];
                end else if (nb[1]) begin
                    cur_addr_d = 7'h00;
                    cg_sel_d   = 1'b0;
                end else if (nb[0]) begin
                    cur_addr_d = 7'h00;
                    inc_d      = 1'b1;
                    cg_sel_d   = 1'b0;
                    clr_cnt_d  = CW'(CLEAR_CYCLES);
                end
            end
        end

        // readback sees the pre-write contents of this cycle
        rd_char_d = cells_q[rd_addr];
    end

    // decoder state, display shadow and readback registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q      <= PH_HIGH;
            hi_rs_q      <= 1'b0;
            hi_nib_q     <= 4'h0;
            byte_valid_q <= 1'b0;
            byte_rs_q    <= 1'b0;
            byte_data_q  <= 8'h00;
            four_bit_q   <= 1'b0;
            disp_on_q    <= 1'b0;
            cur_addr_q   <= 7'h00;
            inc_q        <= 1'b1;
            cg_sel_q     <= 1'b0;
            proto_err_q  <= 1'b0;
            clr_cnt_q    <= '0;
            rd_char_q    <= 8'h20;
            for (int i = 0; i < 32; i++) begin
                cells_q[i] <= 8'h20;
            end
        end else begin
            phase_q      <= phase_d;
            hi_rs_q      <= hi_rs_d;
            hi_nib_q     <= hi_nib_d;
            byte_valid_q <= byte_valid_d;
            byte_rs_q    <= byte_rs_d;
            byte_data_q  <= byte_data_d;
            four_bit_q   <= four_bit_d;
            disp_on_q    <= disp_on_d;
            cur_addr_q   <= cur_addr_d;
            inc_q        <= inc_d;
            cg_sel_q     <= cg_sel_d;
            proto_err_q  <= proto_err_d;
            clr_cnt_q    <= clr_cnt_d;
            rd_char_q    <= rd_char_d;
            cells_q      <= cells_d;
        end
    end

    assign byte_valid = byte_valid_q;
    assign byte_rs    = byte_rs_q;
    assign byte_data  = byte_data_q;
    assign four_bit   = four_bit_q;
    assign disp_on    = disp_on_q;
    assign cur_addr   = cur_addr_q;
    assign clear_busy = (clr_cnt_q != '0);
    assign proto_err  = proto_err_q;
    assign rd_char    = rd_char_q;

endmodule

// File: tb/tb_hd44780_rx.sv
// Directed bench for hd44780_rx: drives bus nibbles, scoreboards every
// byte_valid strobe against expected bytes and checks status and readback.
module tb_hd44780_rx;

    logic       clk;
    logic       rst_n;
    logic       byte_valid;
    logic       byte_rs;
    logic [7:0] byte_data;
    logic       four_bit;
    logic       disp_on;
    logic [6:0] cur_addr;
    logic       clear_busy;
    logic       proto_err;
    logic       timing_err;
    logic [4:0] rd_addr;
    logic [7:0] rd_char;

    int n_cmp = 0;
    int n_err = 0;

    logic [8:0] exp_q[$];
    logic [7:0] exp_cell [32];

    hd44780_rx_if lcd_if ();

    hd44780_rx #(
        .SYNC_STAGES (2),
        .CLEAR_CYCLES(32),
        .MIN_EN_HIGH (12)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lcd       (lcd_if),
        .byte_valid(byte_valid),
        .byte_rs   (byte_rs),
        .byte_data (byte_data),
        .four_bit  (four_bit),
        .disp_on   (disp_on),
        .cur_addr  (cur_addr),
        .clear_busy(clear_busy),
        .proto_err (proto_err),
        .timing_err(timing_err),
        .rd_addr   (rd_addr),
        .rd_char   (rd_char)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every byte_valid strobe must match the oldest expected byte
    always @(negedge clk) begin
        if (rst_n === 1'b1 && byte_valid === 1'b1) begin
            logic [8:0] e;
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL sb_unexpected observed=0x%0h expected=none", {byte_rs, byte_data});
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                assert ({byte_rs, byte_data} === e) else begin
                    n_err++;
                    $error("FAIL sb_byte observed=0x%0h expected=0x%0h", {byte_rs, byte_data}, e);
                end
            end
        end
    end

    task automatic expect_byte(input logic rs, input logic [7:0] b);
        exp_q.push_back({rs, b});
    endtask

    // called at a posedge; hi = en-high samples, gap = en-low samples after
    task automatic send_nib(input logic rs, input logic [3:0] nib, input int hi, input int gap);
        #1;
        lcd_if.lcd_rs = rs;
        lcd_if.lcd_d  = nib;
        lcd_if.lcd_en = 1'b1;
        repeat (hi) @(posedge clk);
        #1;
        lcd_if.lcd_en = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic send_byte(input logic rs, input logic [7:0] b, input int hi, input int gap);
        expect_byte(rs, b);
        send_nib(rs, b[7:4], hi, gap);
        send_nib(rs, b[3:0], hi, gap);
    endtask

    task automatic data_wr(input logic [7:0] b);
        if (cur_addr[5:4] == 2'b00) exp_cell[{cur_addr[6], cur_addr[3:0]}] = b;
        send_byte(1'b1, b, 20, 20);
    endtask

    task automatic read_cell(input string tag, input logic [4:0] idx, input logic [7:0] exp);
        #1;
        rd_addr = idx;
        @(posedge clk);
        @(negedge clk);
        check(tag, {24'h0, rd_char}, {24'h0, exp});
        @(posedge clk);
    endtask

    task automatic check_addr(input string tag, input logic [6:0] exp);
        @(negedge clk);
        check(tag, {25'h0, cur_addr}, {25'h0, exp});
        @(posedge clk);
    endtask

    task automatic check_all_cells(input string tag);
        for (int i = 0; i < 32; i++) begin
            read_cell(tag, 5'(i), exp_cell[i]);
        end
    endtask

    task automatic reset_cells_model();
        for (int i = 0; i < 32; i++) exp_cell[i] = 8'h20;
    endtask

    initial begin
        int busy_cnt;
        rst_n         = 1'b0;
        rd_addr       = 5'd0;
        lcd_if.lcd_rs = 1'b0;
        lcd_if.lcd_en = 1'b0;
        lcd_if.lcd_d  = 4'h0;
        reset_cells_model();
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_byte_valid", {31'h0, byte_valid}, 32'h0);
        check("rst_byte_rs",    {31'h0, byte_rs},    32'h0);
        check("rst_byte_data",  {24'h0, byte_data},  32'h0);
        check("rst_four_bit",   {31'h0, four_bit},   32'h0);
        check("rst_disp_on",    {31'h0, disp_on},    32'h0);
        check("rst_cur_addr",   {25'h0, cur_addr},   32'h0);
        check("rst_clear_busy", {31'h0, clear_busy}, 32'h0);
        check("rst_proto_err",  {31'h0, proto_err},  32'h0);
        check("rst_timing_err", {31'h0, timing_err}, 32'h0);
        check("rst_rd_char",    {24'h0, rd_char},    32'h20);
        rst_n = 1'b1;
        @(posedge clk);

        // init: first nibble also checks byte_valid latency
        expect_byte(1'b0, 8'h30);
        send_nib(1'b0, 4'h3, 20, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("lat_early", {31'h0, byte_valid}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("lat_on", {31'h0, byte_valid}, 32'h1);
        repeat (1000) @(posedge clk);
        expect_byte(1'b0, 8'h30);
        send_nib(1'b0, 4'h3, 20, 1000);
        expect_byte(1'b0, 8'h30);
        send_nib(1'b0, 4'h3, 20, 1000);
        @(negedge clk);
        check("init_still_8bit", {31'h0, four_bit}, 32'h0);
        @(posedge clk);
        expect_byte(1'b0, 8'h20);
        send_nib(1'b0, 4'h2, 20, 1000);
        @(negedge clk);
        check("init_four_bit", {31'h0, four_bit}, 32'h1);
        @(posedge clk);
        send_byte(1'b0, 8'h28, 20, 1000);
        send_byte(1'b0, 8'h0C, 20, 1000);
        @(negedge clk);
        check("init_disp_on", {31'h0, disp_on}, 32'h1);
        @(posedge clk);
        send_byte(1'b0, 8'h06, 20, 1000);
        expect_byte(1'b0, 8'h01);
        send_nib(1'b0, 4'h0, 20, 1000);
        send_nib(1'b0, 4'h1, 20, 0);
        busy_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (clear_busy === 1'b1) busy_cnt++;
        end
        check("clear_len", busy_cnt, 32);
        repeat (800) @(posedge clk);
        send_byte(1'b0, 8'h80, 20, 1000);
        check_addr("init_cur_addr", 7'h00);

        // data writes on line 0
        data_wr(8'h31);
        data_wr(8'h32);
        data_wr(8'h3A);
        read_cell("rd_cell0", 5'd0, 8'h31);
        read_cell("rd_cell1", 5'd1, 8'h32);
        read_cell("rd_cell2", 5'd2, 8'h3A);
        check_addr("addr_after_3", 7'h03);

        // line 1 and wrap points
        send_byte(1'b0, 8'hC0, 20, 20);
        data_wr(8'h41);
        read_cell("rd_cell16", 5'd16, 8'h41);
        check_addr("addr_0x41", 7'h41);
        send_byte(1'b0, 8'hA7, 20, 20);
        check_addr("addr_0x27", 7'h27);
        data_wr(8'h58);
        check_addr("wrap_27_40", 7'h40);
        check_all_cells("no_write_0x27");

        send_byte(1'b0, 8'h04, 20, 20);
        send_byte(1'b0, 8'h80, 20, 20);
        data_wr(8'h5A);
        check_addr("wrap_00_67", 7'h67);
        read_cell("rd_dec_cell0", 5'd0, 8'h5A);
        send_byte(1'b0, 8'hC0, 20, 20);
        data_wr(8'h5B);
        check_addr("wrap_40_27", 7'h27);
        read_cell("rd_dec_cell16", 5'd16, 8'h5B);
        send_byte(1'b0, 8'h06, 20, 20);
        send_byte(1'b0, 8'hE7, 20, 20);
        data_wr(8'h59);
        check_addr("wrap_67_00", 7'h00);

        // CGRAM select discards data until a DDRAM address command
        send_byte(1'b0, 8'h40, 20, 20);
        send_byte(1'b1, 8'h33, 20, 20);
        check_addr("cg_no_step", 7'h00);
        send_byte(1'b0, 8'h80, 20, 20);
        check_all_cells("cg_no_write");

        // rs mismatch between nibbles
        send_byte(1'b0, 8'h85, 20, 20);
        send_nib(1'b0, 4'h8, 20, 20);
        send_nib(1'b1, 4'h0, 20, 20);
        @(negedge clk);
        check("proto_err_set", {31'h0, proto_err}, 32'h1);
        check("proto_drop_addr", {25'h0, cur_addr}, 32'h05);
        @(posedge clk);
        send_byte(1'b0, 8'h80, 20, 20);
        check_addr("proto_recover", 7'h00);

        // reset in the middle of a clear with half a nibble pair held
        send_byte(1'b0, 8'h01, 20, 1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("busy_before_rst", {31'h0, clear_busy}, 32'h1);
        @(posedge clk);
        send_nib(1'b1, 4'h4, 20, 1);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy",     {31'h0, clear_busy}, 32'h0);
        check("mid_rst_four_bit", {31'h0, four_bit},   32'h0);
        check("mid_rst_proto",    {31'h0, proto_err},  32'h0);
        check("mid_rst_disp_on",  {31'h0, disp_on},    32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        reset_cells_model();
        @(posedge clk);
        read_cell("mid_rst_cell0", 5'd0, 8'h20);
        read_cell("mid_rst_cell16", 5'd16, 8'h20);

        // back to 4-bit mode, write a cell, then send data while clearing
        expect_byte(1'b0, 8'h20);
        send_nib(1'b0, 4'h2, 20, 20);
        data_wr(8'h44);
        read_cell("post_rst_cell0", 5'd0, 8'h44);
        check_addr("post_rst_addr", 7'h01);
        expect_byte(1'b0, 8'h01);
        send_nib(1'b0, 4'h0, 12, 1);
        send_nib(1'b0, 4'h1, 12, 1);
        repeat (2) @(posedge clk);
        expect_byte(1'b1, 8'h41);
        send_nib(1'b1, 4'h4, 12, 1);
        send_nib(1'b1, 4'h1, 12, 1);
        repeat (60) @(posedge clk);
        reset_cells_model();
        @(negedge clk);
        check("busy_data_proto", {31'h0, proto_err}, 32'h1);
        check("busy_data_addr", {25'h0, cur_addr}, 32'h00);
        @(posedge clk);
        check_all_cells("clear_fill");

        // short enable pulse followed by normal pulses
        @(negedge clk);
        check("timing_err_pre", {31'h0, timing_err}, 32'h0);
        @(posedge clk);
`ifdef HD44780_TIMING_CHECK_EN
        expect_byte(1'b0, 8'h82);
        send_nib(1'b0, 4'hC, 5, 20);
        send_nib(1'b0, 4'h8, 20, 20);
        send_nib(1'b0, 4'h2, 20, 20);
        @(negedge clk);
        check("short_pulse_err", {31'h0, timing_err}, 32'h1);
        check("short_pulse_addr", {25'h0, cur_addr}, 32'h02);
        @(posedge clk);
`else
        expect_byte(1'b0, 8'hC8);
        send_nib(1'b0, 4'hC, 5, 20);
        send_nib(1'b0, 4'h8, 20, 20);
        expect_byte(1'b0, 8'h20);
        send_nib(1'b0, 4'h2, 20, 20);
        send_nib(1'b0, 4'h0, 20, 20);
        @(negedge clk);
        check("short_pulse_err", {31'h0, timing_err}, 32'h0);
        check("short_pulse_addr", {25'h0, cur_addr}, 32'h48);
        @(posedge clk);
`endif

        repeat (50) @(posedge clk);
        check("sb_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hd44780_rx.md
Name: hd44780_rx

Overview:
- Receive-side model of the 4-bit HD44780 character-LCD bus that our clock drivers transmit on (rs, en, data[7:4]).
- Samples the bus, rebuilds command and data bytes, and decodes the command subset our drivers use.
- Keeps a 2x16 shadow of visible display RAM, with a random-access readback port.
- Serves as an on-chip display mirror for loopback, board debug and bench self-check of any display driver.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on lcd_rs, lcd_en and lcd_d; minimum 2.
- CLEAR_CYCLES, 32: clk cycles clear_busy stays high after a clear command; minimum 32, one visible cell filled per cycle.
- MIN_EN_HIGH, 12: minimum lcd_en high time in clk cycles; used only with HD44780_TIMING_CHECK_EN.

Ports:
- clk, in, 1: system clock, all logic on rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- lcd_rs, in, 1: register select; 0 = command, 1 = data.
- lcd_en, in, 1: enable strobe; the nibble is latched on its falling edge.
- lcd_d, in, 4: bus data D7..D4.
- byte_valid, out, 1: one-cycle strobe, a complete byte was accepted.
- byte_rs, out, 1: rs of the accepted byte.
- byte_data, out, 8: the accepted byte.
- four_bit, out, 1: 1 once 4-bit mode is active.
- disp_on, out, 1: display-on bit (D) from the display-control command.
- cur_addr, out, 7: DDRAM address counter.
- clear_busy, out, 1: high while a clear is in progress.
- proto_err, out, 1: sticky protocol error, cleared only by reset.
- timing_err, out, 1: sticky timing error; tied 0 when the macro is off.
- rd_addr, in, 5: readback index; [4] = line, [3:0] = column.
- rd_char, out, 8: cell contents, registered, 1-cycle latency.

Behaviour:
- Reset values:
  - byte_valid, byte_rs, four_bit, disp_on, clear_busy, proto_err, timing_err = 0.
  - byte_data = 0x00, cur_addr = 0x00, rd_char = 0x20.
  - Internal state: increment mode = 1, nibble phase = HIGH, all 32 cells = 0x20.
- Input path and latency:
  - All three inputs pass through SYNC_STAGES flip-flops; the falling edge of lcd_en is detected on the synchronised copy.
  - rs and nibble are taken from the synchronised copies in the same cycle as the edge.
  - byte_valid pulses exactly SYNC_STAGES+1 cycles after the first clk edge that samples lcd_en low.
- 8-bit mode (four_bit = 0):
  - Each falling edge forms the byte {nibble, 4'h0} and is accepted as a complete byte.
  - A function set (0x20-0x3F) with DL (bit 4) = 0 sets four_bit = 1 and forces nibble phase to HIGH.
- 4-bit mode:
  - Nibble states are HIGH -> LOW -> HIGH; the byte is formed on the LOW edge.
  - If rs differs between the two nibbles: byte dropped, proto_err set, phase returns to HIGH.
- Command decode (rs = 0), highest set bit wins:
  - 0x80-0xFF (set DDRAM address): cur_addr = byte[6:0].
  - 0x40-0x7F (set CGRAM address): sets cg_sel; subsequent data writes are discarded until the next DDRAM-address, clear or home command.
  - 0x20-0x3F (function set): DL is honoured in both modes; DL = 1 returns to 8-bit mode.
  - 0x08-0x0F (display control): disp_on = bit 2; cursor and blink bits ignored.
  - 0x04-0x07 (entry mode): increment mode = bit 1; display-shift bit ignored.
  - 0x02-0x03 (home): cur_addr = 0.
  - 0x01 (clear): cur_addr = 0, increment mode = 1, clear_busy high for CLEAR_CYCLES cycles while cells are filled with 0x20.
- Data write (rs = 1, cg_sel = 0):
  - Cell write occurs only if cur_addr is in 0x00-0x0F (line 0) or 0x40-0x4F (line 1); other addresses store nothing.
  - cur_addr always steps after a data write.
- Address counter stepping:
  - Increment: 0x27 -> 0x40, 0x67 -> 0x00.
  - Decrement: 0x40 -> 0x27, 0x00 -> 0x67.
- Byte arriving while clear_busy = 1: still reported on byte_valid, but has no effect; proto_err set.
- Readback:
  - rd_char = cell[rd_addr] registered.
  - A same-cycle write to the same cell returns the old value.
- Reset mid-operation: everything returns to reset values immediately, including a half-received nibble pair and a clear in progress.
- byte_valid is reported for all accepted bytes, including ignored commands.

Optional Feature:
- Macro: HD44780_TIMING_CHECK_EN.
- Enabled:
  - A counter measures synchronised lcd_en high time; it saturates at MIN_EN_HIGH.
  - On a falling edge with high time < MIN_EN_HIGH: the nibble is discarded, nibble phase is unchanged, timing_err is set (sticky).
- Disabled: no counter; every falling edge is accepted; timing_err is constant 0.

Test Plan:
- Init sequence, 1000-cycle gaps: nibbles 3,3,3,2 then 2,8 / 0,C / 0,6 / 0,1 / 8,0, all rs = 0 -> four_bit = 1, disp_on = 1, cur_addr = 0x00, clear_busy high 32 cycles, byte_data strobes 0x30,0x30,0x30,0x20,0x28,0x0C,0x06,0x01,0x80.
- After init, rs = 1 nibbles 3,1 / 3,2 / 3,A -> rd_addr 0,1,2 return 0x31,0x32,0x3A; cur_addr = 0x03.
- Command 0xC0 then data 0x41 -> rd_addr 16 returns 0x41, cur_addr = 0x41; cur_addr 0x27 + data 0x58 -> cur_addr 0x40, no cell changed.
- High nibble with rs = 0 then low nibble with rs = 1 -> no byte_valid, proto_err = 1; next pair 0x80 decodes correctly.
- Data 0x41 sent 5 cycles after a clear command -> byte_valid pulses, all 32 cells read 0x20, proto_err = 1.
- With HD44780_TIMING_CHECK_EN: en high 5 cycles -> timing_err = 1, nibble dropped; next 20-cycle pulses decode normally. Without the macro: the same pulse is accepted.
